// File: rtl/fifo_rd_checker_if.sv
// fifo_rd_checker_if: FIFO read-port handshake (request, empty flag, read data).
interface fifo_rd_checker_if #(
    parameter int DW = 8
) ();
    logic          rreqb;
    logic          emptyb;
    logic [DW-1:0] rdatb;

    modport master (output rreqb, input emptyb, input rdatb);
    modport slave  (input rreqb, output emptyb, output rdatb);
endinterface

// File: rtl/fifo_rd_checker.sv
// fifo_rd_checker: read-side FIFO consumer issuing traffic-shaped reads and checking an incrementing pattern.
// Define FIFO_RD_CHK_RESYNC_EN to resynchronise the expected word to rdatb+1 after a mismatch.
module fifo_rd_checker #(
    parameter int unsigned     DW        = 8,
    parameter int unsigned     CW        = 16,
    parameter int unsigned     RD_LAT    = 1,
    parameter logic [DW-1:0]   SEED      = '0,
    parameter int unsigned     THR_DIV   = 4,
    parameter int unsigned     BURST_LEN = 8,
    parameter int unsigned     GAP_LEN   = 4,
    parameter int unsigned     NUM_RD    = 0
) (
    input  logic                clkb,
    input  logic                rstb,
    input  logic                en,
    input  logic [1:0]          mode,
    fifo_rd_checker_if.master   rd,
    output logic [CW-1:0]       rd_cnt,
    output logic [CW-1:0]       err_cnt,
    output logic                err_flag,
    output logic                done
);
    localparam int TW = $clog2(THR_DIV + 1);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int GW = $clog2(GAP_LEN + 1);
    localparam logic [CW-1:0] MAX = '1;

    typedef enum logic [1:0] {IDLE, RUN, GAP} st_t;

    st_t           st;
    logic [1:0]    md;
    logic [TW-1:0] dcnt;
    logic [BW-1:0] bcnt;
    logic [GW-1:0] gcnt;
    logic [31:0]   iss;
    logic [31:0]   nck;
    logic [DW-1:0] expd;
    logic          chk;
    logic          ok;
    logic          gate;
    logic          lim;

    always_comb begin
        gate = (md == 2'd1) ? (dcnt == '0) : 1'b1;
        lim  = (NUM_RD == 0) || (iss < NUM_RD);
        ok   = rd.rdatb == expd;
    end

    assign rd.rreqb = (st == RUN) & ~rd.emptyb & gate & ~done & lim;

    // valid bit travels with each request until its data is due on rdatb
    if (RD_LAT == 0) begin : g_lat
        assign chk = rd.rreqb;
    end else begin : g_lat
        logic [RD_LAT-1:0] sh;
        always_ff @(posedge clkb)
            sh <= rstb ? '0 : RD_LAT'({sh, rd.rreqb});
        assign chk = sh[RD_LAT-1];
    end

    always_ff @(posedge clkb) begin
        if (rstb) begin
            st       <= IDLE;
            md       <= '0;
            dcnt     <= '0;
            bcnt     <= '0;
            gcnt     <= '0;
            iss      <= '0;
            nck      <= '0;
            expd     <= SEED;
            rd_cnt   <= '0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (rd.rreqb)
                iss <= iss + 1;
            if (chk) begin
                nck    <= nck + 1;
                rd_cnt <= (rd_cnt == MAX) ? rd_cnt : rd_cnt + 1'b1;
                if (!ok) begin
                    err_cnt  <= (err_cnt == MAX) ? err_cnt : err_cnt + 1'b1;
                    err_flag <= 1'b1;
                end
`ifdef FIFO_RD_CHK_RESYNC_EN
                expd <= (ok ? expd : rd.rdatb) + 1'b1;
`else
                expd <= expd + 1'b1;
`endif
                if (NUM_RD != 0 && nck == NUM_RD - 1)
                    done <= 1'b1;
            end
            if (st == IDLE) begin
                dcnt <= '0;
                bcnt <= '0;
                gcnt <= '0;
                if (en & ~done) begin
                    st <= RUN;
                    md <= mode;
                end
            end else if (~en | done) begin
                st <= IDLE;
            end else if (st == RUN) begin
                dcnt <= (dcnt == TW'(THR_DIV - 1)) ? '0 : dcnt + 1'b1;
                if (md == 2'd2 && rd.rreqb) begin
                    bcnt <= (bcnt == BW'(BURST_LEN - 1)) ? '0 : bcnt + 1'b1;
                    if (bcnt == BW'(BURST_LEN - 1))
                        st <= GAP;
                end
            end else begin
                gcnt <= (gcnt == GW'(GAP_LEN - 1)) ? '0 : gcnt + 1'b1;
                if (gcnt == GW'(GAP_LEN - 1))
                    st <= RUN;
            end
        end
    end
endmodule

// File: tb/tb_fifo_rd_checker.sv
// tb_fifo_rd_checker: randomized traffic against a cycle-indexed reference model of the read checker.
module tb_fifo_rd_checker;
    localparam int DW = 8, CW = 5, RD_LAT = 2, THR_DIV = 3, BURST_LEN = 5, GAP_LEN = 3, NUM_RD = 40;
    localparam logic [7:0] SEED = 8'hF9;
    localparam int MAXC = (1 << CW) - 1;

    logic          clkb = 1'b0;
    logic          rstb = 1'b1;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] err_cnt;
    logic          err_flag;
    logic          done;

    fifo_rd_checker_if #(.DW(DW)) rif ();

    fifo_rd_checker #(
        .DW(DW), .CW(CW), .RD_LAT(RD_LAT), .SEED(SEED), .THR_DIV(THR_DIV),
        .BURST_LEN(BURST_LEN), .GAP_LEN(GAP_LEN), .NUM_RD(NUM_RD)
    ) dut (
        .clkb(clkb), .rstb(rstb), .en(en), .mode(mode), .rd(rif),
        .rd_cnt(rd_cnt), .err_cnt(err_cnt), .err_flag(err_flag), .done(done)
    );

    always #5 clkb = ~clkb;

    typedef struct {int c; logic [7:0] w;} pend_t;

    pend_t      pq[$];
    logic [7:0] fq[$];
    int         nchk = 0, nerr = 0, k = 0, npulse = 0;
    int         m_rd, m_err, m_iss, acc, gap_until, rs;
    bit         m_flag, en_p, rst_p, run_p;
    logic [7:0] m_exp, nv;
    logic [1:0] m_mode, mode_p;

    task automatic check(string tag, int act, int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, k);
        end
    endtask

    function automatic int sat(int v);
        return v > MAXC ? MAXC : v;
    endfunction

    task automatic mreset();
        pq.delete();
        m_rd = 0; m_err = 0; m_iss = 0; m_flag = 0; m_exp = SEED; acc = 0; gap_until = -1;
    endtask

    // one delivered word against the incrementing pattern
    task automatic score(logic [7:0] w);
        if (w != m_exp) begin
            m_err++;
            m_flag = 1;
        end
`ifdef FIFO_RD_CHK_RESYNC_EN
        m_exp = w + 8'd1;
`else
        m_exp = m_exp + 8'd1;
`endif
        m_rd++;
    endtask

    task automatic push_word(bit corrupt);
        int r = $urandom_range(99);
        if (corrupt && r < 6) nv = nv + 8'd1;
        if (corrupt && r >= 6 && r < 10) fq.push_back(nv - 8'd1);
        else begin
            fq.push_back(nv);
            nv = nv + 8'd1;
        end
    endtask

    task automatic cycle(int arrp, bit corrupt, bit rst_now, bit en_now, logic [1:0] md_now);
        bit run, gate, m_done, exp_rq;
        logic [7:0] w;
        @(posedge clkb);
        #1;
        k++;
        if (rst_p) mreset();
        else while (pq.size() > 0 && pq[0].c <= k - RD_LAT - 1) begin
            score(pq[0].w);
            void'(pq.pop_front());
        end
        if (int'($urandom_range(99)) < arrp) push_word(corrupt);
        rstb = rst_now;
        en = en_now;
        mode = md_now;
        rif.emptyb = (fq.size() == 0);
        rif.rdatb = 8'($urandom);
        foreach (pq[i]) if (pq[i].c == k - RD_LAT) rif.rdatb = pq[i].w;
        run = en_p & !rst_p & !rst_now;
        if (run && !run_p) begin
            rs = k; m_mode = mode_p; acc = 0; gap_until = -1;
        end
        gate = (m_mode == 2'd1) ? ((k - rs) % THR_DIV == 0) : (m_mode == 2'd2) ? (k > gap_until) : 1'b1;
        m_done = m_rd >= NUM_RD;
        exp_rq = run & (fq.size() != 0) & gate & !m_done & (m_iss < NUM_RD);
        @(negedge clkb);
        if (!rst_now) begin
            check("rreqb", rif.rreqb, exp_rq);
            check("rd_cnt", rd_cnt, sat(m_rd));
            check("err_cnt", err_cnt, sat(m_err));
            check("err_flag", err_flag, m_flag);
            check("done", done, m_done);
        end
        if (rif.rreqb && !rst_now) begin
            w = fq.size() > 0 ? fq.pop_front() : 8'($urandom);
            pq.push_back('{c: k, w: w});
            m_iss++;
            npulse++;
            if (m_mode == 2'd2) begin
                acc++;
                if (acc % BURST_LEN == 0) gap_until = k + GAP_LEN;
            end
        end
        en_p = en_now; rst_p = rst_now; mode_p = md_now; run_p = run;
    endtask

    task automatic rst_phase();
        repeat (2) cycle(0, 0, 1, 0, 2'd0);
        fq.delete();
        nv = SEED;
        npulse = 0;
    endtask

    task automatic preload(int n, bit corrupt);
        repeat (n) push_word(corrupt);
    endtask

    task automatic run_phase(int n, int md, int enp, int arrp, bit corrupt, int rst_at, bit noise);
        for (int i = 0; i < n; i++) begin
            logic [1:0] m = (noise && $urandom_range(9) == 0) ? 2'($urandom) : 2'(md);
            cycle(arrp, corrupt, i == rst_at, int'($urandom_range(99)) < enp, m);
        end
        repeat (RD_LAT + 4) cycle(0, 0, 0, 0, 2'(md));
    endtask

    initial begin
        rif.emptyb = 1'b1;
        rif.rdatb = '0;
        rst_phase();
        preload(16, 0);
        run_phase(30, 0, 100, 0, 0, -1, 0);
        check("t1_rd_cnt", rd_cnt, 16);
        check("t1_pulses", npulse, 16);
        check("t1_err_cnt", err_cnt, 0);

        rst_phase();
        preload(8, 0);
        run_phase(60, 1, 100, 70, 0, -1, 1);

        rst_phase();
        preload(24, 0);
        run_phase(90, 2, 100, 60, 0, -1, 1);

        rst_phase();
        fq.push_back(SEED);
        fq.push_back(SEED + 8'd1);
        fq.push_back(SEED + 8'd2);
        fq.push_back(SEED + 8'd4);
        fq.push_back(SEED + 8'd5);
        run_phase(15, 0, 100, 0, 0, -1, 0);
`ifdef FIFO_RD_CHK_RESYNC_EN
        check("t4_err_cnt", err_cnt, 1);
`else
        check("t4_err_cnt", err_cnt, 2);
`endif
        check("t4_err_flag", err_flag, 1);

        rst_phase();
        preload(60, 1);
        run_phase(100, 0, 100, 0, 1, -1, 0);
        check("t5_done", done, 1);
        check("t5_pulses", npulse, NUM_RD);
        check("t5_rd_cnt_sat", rd_cnt, MAXC);

        rst_phase();
        preload(10, 0);
        run_phase(40, 2, 100, 100, 0, 6, 0);

        for (int p = 0; p < 6; p++) begin
            rst_phase();
            preload($urandom_range(12), 1);
            run_phase(100 + $urandom_range(60), $urandom_range(3), 80 + $urandom_range(20),
                      30 + $urandom_range(70), 1, (p % 2 == 1) ? $urandom_range(80) : -1, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
